// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore control sequencer for the Phase 1/2 datapath. Steps through
// the three fetch steps (T0-T2) and the per-instruction execute steps (T3-T7),
// decoding every datapath strobe combinationally from the current step and the
// live opcode in IR[31:27].
//
// Ports
//   clk       in   system clock, rising-edge active
//   clr       in   asynchronous active-high reset (forces RESET immediately)
//   IR        in   instruction register (opcode IR[31:27]; fields decoded by
//                  the datapath select-and-encode logic, not here)
//   Stop      in   halt request, honoured only on an instruction's final edge
//   Run       out  high in T0-T7, low in RESET and HALT
//   Illegal   out  sticky flag, set when an undefined opcode reaches T3
//   PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout
//             out  bus drive strobes
//   PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin
//             out  register load strobes
//   Gra, Grb, Grc
//             out  register-field selects for Rin/Rout/BAout
//   Read, Write
//             out  memory strobes
//   OpCode    out  ALU function select
//   State     out  current step encoding (debug only)
// -----------------------------------------------------------------------------
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        Illegal,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  OpCode,
    output logic [4:0]  State
);

    localparam logic [4:0] INC_CODE = 5'd12;
    localparam logic [4:0] ADD_CODE = 5'd3;

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_T0    = 5'd1,
        S_T1    = 5'd2,
        S_T2    = 5'd3,
        S_T3    = 5'd4,
        S_T4    = 5'd5,
        S_T5    = 5'd6,
        S_T6    = 5'd7,
        S_T7    = 5'd8,
        S_HALT  = 5'd9
    } state_t;

    state_t     state;
    state_t     state_next;
    state_t     last_state;
    state_t     end_next;
    logic       illegal_set;
    logic [4:0] op;

    logic is_rtype, is_imm, is_ldi, is_ld, is_st, is_muldiv;
    logic is_mfhi, is_mflo, is_nop, is_halt, is_legal;

    // Register fields are routed by the datapath's select-and-encode logic.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    // Immediate opcodes borrow the matching register-form ALU function, so
    // opcode 12 (addi) never reaches the ALU where it would mean increment.
    function automatic logic [4:0] imm_alu_code(input logic [4:0] code);
        case (code)
            5'd12:   imm_alu_code = ADD_CODE;
            5'd13:   imm_alu_code = 5'd5;
            5'd14:   imm_alu_code = 5'd6;
            default: imm_alu_code = ADD_CODE;
        endcase
    endfunction

    assign op = IR[31:27];

    always_comb begin
        is_rtype  = (op >= 5'd3) && (op <= 5'd8);
        is_imm    = (op >= 5'd12) && (op <= 5'd14);
        is_ldi    = (op == 5'd1);
        is_ld     = (op == 5'd0);
        is_st     = (op == 5'd2);
        is_muldiv = (op == 5'd15) || (op == 5'd16);
        is_mfhi   = (op == 5'd24);
        is_mflo   = (op == 5'd25);
        is_nop    = (op == 5'd26);
        is_halt   = (op == 5'd27);
        is_legal  = is_rtype | is_imm | is_ldi | is_ld | is_st | is_muldiv |
                    is_mfhi | is_mflo | is_nop | is_halt;
    end

    // Final execute step of the current instruction class.
    always_comb begin
        last_state = S_T3;
        if (is_rtype || is_imm || is_ldi) last_state = S_T5;
        else if (is_muldiv)               last_state = S_T6;
        else if (is_ld || is_st)          last_state = S_T7;
    end

    assign end_next = Stop ? S_HALT : S_T0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_RESET;
            Illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (illegal_set) Illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        illegal_set = 1'b0;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3: begin
                if (!is_legal) begin
                    illegal_set = 1'b1;
                    state_next  = S_HALT;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else if (last_state == S_T3) begin
                    state_next = end_next;
                end else begin
                    state_next = S_T4;
                end
            end
            // Using >= keeps the sequencer from running past T7 even if IR
            // were disturbed mid-instruction.
            S_T4:    state_next = (state >= last_state) ? end_next : S_T5;
            S_T5:    state_next = (state >= last_state) ? end_next : S_T6;
            S_T6:    state_next = (state >= last_state) ? end_next : S_T7;
            S_T7:    state_next = end_next;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        BAout    = 1'b0;
        Rout     = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        OpCode   = 5'd0;
        Run      = (state != S_RESET) && (state != S_HALT);
        State    = state;

        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                Zin    = 1'b1;
                OpCode = INC_CODE;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_rtype || is_imm) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_muldiv) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_mfhi) begin
                    HIout = 1'b1;
                    Gra   = 1'b1;
                    Rin   = 1'b1;
                end else if (is_mflo) begin
                    LOout = 1'b1;
                    Gra   = 1'b1;
                    Rin   = 1'b1;
                end
            end
            S_T4: begin
                if (is_rtype) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    OpCode = op;
                end else if (is_imm) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    OpCode = imm_alu_code(op);
                end else if (is_ldi || is_ld || is_st) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    OpCode = ADD_CODE;
                end else if (is_muldiv) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    OpCode = op;
                end
            end
            S_T5: begin
                if (is_rtype || is_imm || is_ldi) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    // Store data comes from the register file, not memory.
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench for control_unit. The stimulus process issues instructions
// and, for every cycle it drives, pushes the expected output word computed
// from a per-instruction-class step table. A separate monitor pops and
// compares on every falling edge while expectations are pending.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        Stop;
    logic        Run, Illegal;
    logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic        Gra, Grb, Grc, Read, Write;
    logic [4:0]  OpCode;
    logic [4:0]  State;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .Run(Run), .Illegal(Illegal),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
        .OpCode(OpCode), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word layout (bit positions).
    localparam logic [29:0] RUN    = 30'd1 << 29;
    localparam logic [29:0] ILL    = 30'd1 << 28;
    localparam logic [29:0] PCOUT  = 30'd1 << 27;
    localparam logic [29:0] ZLOW   = 30'd1 << 26;
    localparam logic [29:0] ZHIGH  = 30'd1 << 25;
    localparam logic [29:0] MDROUT = 30'd1 << 24;
    localparam logic [29:0] HIOUT  = 30'd1 << 23;
    localparam logic [29:0] LOOUT  = 30'd1 << 22;
    localparam logic [29:0] COUT   = 30'd1 << 21;
    localparam logic [29:0] BAOUT  = 30'd1 << 20;
    localparam logic [29:0] ROUT   = 30'd1 << 19;
    localparam logic [29:0] PCIN   = 30'd1 << 18;
    localparam logic [29:0] MARIN  = 30'd1 << 17;
    localparam logic [29:0] MDRIN  = 30'd1 << 16;
    localparam logic [29:0] IRIN   = 30'd1 << 15;
    localparam logic [29:0] YIN    = 30'd1 << 14;
    localparam logic [29:0] ZIN    = 30'd1 << 13;
    localparam logic [29:0] HIIN   = 30'd1 << 12;
    localparam logic [29:0] LOIN   = 30'd1 << 11;
    localparam logic [29:0] RIN    = 30'd1 << 10;
    localparam logic [29:0] GRA    = 30'd1 << 9;
    localparam logic [29:0] GRB    = 30'd1 << 8;
    localparam logic [29:0] GRC    = 30'd1 << 7;
    localparam logic [29:0] READ   = 30'd1 << 6;
    localparam logic [29:0] WRITE  = 30'd1 << 5;

    logic [29:0] obs;
    assign obs = {Run, Illegal, PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
                  Cout, BAout, Rout, PCin, MARin, MDRin, IRin, Yin, Zin, HIin,
                  LOin, Rin, Gra, Grb, Grc, Read, Write, OpCode};

    logic [29:0] exp_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          ill_m  = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit op_legal(input logic [4:0] op);
        return (op <= 5'd8) || (op >= 5'd12 && op <= 5'd16) ||
               (op >= 5'd24 && op <= 5'd27);
    endfunction

    function automatic int seq_len(input logic [4:0] op);
        if ((op >= 5'd3 && op <= 5'd8) || (op >= 5'd12 && op <= 5'd14) || op == 5'd1)
            return 6;
        if (op == 5'd0 || op == 5'd2) return 8;
        if (op == 5'd15 || op == 5'd16) return 7;
        return 4;
    endfunction

    function automatic logic [29:0] step_vec(input logic [4:0] op, input int k);
        logic [29:0] v;
        logic [29:0] alu;
        v = RUN;
        case (k)
            0: return v | PCOUT | MARIN | ZIN | 30'd12;
            1: return v | ZLOW | PCIN | READ | MDRIN;
            2: return v | MDROUT | IRIN;
            default: ;
        endcase
        if (op >= 5'd3 && op <= 5'd8) begin
            if (k == 3) v |= GRB | ROUT | YIN;
            if (k == 4) v |= GRC | ROUT | ZIN | 30'(op);
            if (k == 5) v |= ZLOW | GRA | RIN;
        end else if (op >= 5'd12 && op <= 5'd14) begin
            alu = (op == 5'd12) ? 30'd3 : (op == 5'd13) ? 30'd5 : 30'd6;
            if (k == 3) v |= GRB | ROUT | YIN;
            if (k == 4) v |= COUT | ZIN | alu;
            if (k == 5) v |= ZLOW | GRA | RIN;
        end else if (op <= 5'd2) begin
            if (k == 3) v |= GRB | BAOUT | YIN;
            if (k == 4) v |= COUT | ZIN | 30'd3;
            if (k == 5) v |= (op == 5'd1) ? (ZLOW | GRA | RIN) : (ZLOW | MARIN);
            if (k == 6) v |= (op == 5'd0) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
            if (k == 7) v |= (op == 5'd0) ? (MDROUT | GRA | RIN) : WRITE;
        end else if (op == 5'd15 || op == 5'd16) begin
            if (k == 3) v |= GRA | ROUT | YIN;
            if (k == 4) v |= GRB | ROUT | ZIN | 30'(op);
            if (k == 5) v |= ZLOW | LOIN;
            if (k == 6) v |= ZHIGH | HIIN;
        end else if (op == 5'd24) begin
            v |= HIOUT | GRA | RIN;
        end else if (op == 5'd25) begin
            v |= LOOUT | GRA | RIN;
        end
        return v;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [29:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s: outputs got=%08h expected=%08h", nm, obs, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [29:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        push_exp(30'd0, "reset_assert");
        #1 clr = 1'b1;
        ill_m = 1'b0;
        @(posedge clk); #1;
        push_exp(30'd0, "reset_hold");
        clr = 1'b0;
    endtask

    // Issues one instruction; limit < 0 runs it to completion, otherwise only
    // the first 'limit' steps are driven (used for mid-instruction aborts).
    task automatic run_instr(input logic [31:0] ir, input bit stop_end,
                             input int limit, output bit halted);
        logic [4:0] op;
        int         n;
        int         lim;
        op  = ir[31:27];
        n   = seq_len(op);
        lim = (limit < 0) ? n : limit;
        for (int k = 0; k < lim; k++) begin
            @(posedge clk); #1;
            if (k == 0) IR = ir;
            Stop = (k == n - 1) ? stop_end : 1'($urandom_range(0, 1));
            push_exp(step_vec(op, k), $sformatf("op%0d_T%0d", op, k));
        end
        halted = (limit < 0) && (stop_end || op == 5'd27 || !op_legal(op));
        if (limit < 0 && !op_legal(op)) ill_m = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            Stop = 1'($urandom_range(0, 1));
            push_exp(ill_m ? ILL : 30'd0, $sformatf("halt_c%0d", i));
        end
    endtask

    initial begin
        bit          h;
        logic [31:0] ir;
        logic [4:0]  op;
        int          legal_ops[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 13, 14, 15, 16, 24, 25, 26};
        int          bad_ops[12]   = '{9, 10, 11, 17, 18, 19, 20, 21, 22, 23, 28, 29};

        clr  = 1'b1;
        IR   = 32'd0;
        Stop = 1'b0;
        do_reset();

        // Directed instructions from each class.
        run_instr(32'h2891_8000, 1'b0, -1, h);   // and r1,r2,r3
        run_instr(32'h6111_FFFB, 1'b0, -1, h);   // addi
        run_instr(32'h0088_0010, 1'b0, -1, h);   // ld
        run_instr(32'h1088_0010, 1'b0, -1, h);   // st
        run_instr(32'h7888_0000, 1'b0, -1, h);   // mul
        run_instr(32'h8088_0000, 1'b0, -1, h);   // div
        run_instr(32'h0888_0010, 1'b0, -1, h);   // ldi
        run_instr(32'h6911_0004, 1'b0, -1, h);   // andi
        run_instr(32'h7111_0004, 1'b0, -1, h);   // ori
        run_instr(32'hC080_0000, 1'b0, -1, h);   // mfhi
        run_instr(32'hC880_0000, 1'b0, -1, h);   // mflo
        run_instr(32'hD000_0000, 1'b0, -1, h);   // nop

        // Abort in the middle of T4, then restart from T0.
        run_instr(32'h2891_8000, 1'b0, 4, h);
        do_reset();
        run_instr(32'h2891_8000, 1'b0, -1, h);

        // halt instruction: absorbing for 10 cycles.
        run_instr(32'hD800_0000, 1'b0, -1, h);
        halt_cycles(10);
        do_reset();

        // Stop sampled at the final step of an add.
        run_instr(32'h1891_8000, 1'b1, -1, h);
        halt_cycles(3);
        do_reset();

        // Undefined opcode 31.
        run_instr(32'hF800_0000, 1'b0, -1, h);
        halt_cycles(4);
        do_reset();

        // Randomized instruction stream.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 19))
                0:       op = 5'(bad_ops[$urandom_range(0, 11)]);
                1:       op = 5'd27;
                2:       op = 5'd31;
                default: op = 5'(legal_ops[$urandom_range(0, 16)]);
            endcase
            ir = {op, 27'($urandom)};
            run_instr(ir, ($urandom_range(0, 19) == 0), -1, h);
            if (h) begin
                halt_cycles(2);
                do_reset();
            end
        end

        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore-style control sequencer for the Phase 1/2 datapath. It steps through fetch (T0–T2) and the per-instruction execute steps (T3–T7), and it drives every bus-out, register-in, memory and ALU-select strobe that the datapath currently receives from hand-written testbench state machines. It sits beside the datapath: it reads the instruction from IR and drives the datapath control ports directly. The Gra/Grb/Grc/Rin/Rout/BAout outputs go through the existing select-and-encode logic.

## Interface
- INC_CODE, 5'd12: ALU function for PC increment. Opcode 12 (addi) is always remapped, so 12 never reaches the ALU raw.
- ADD_CODE, 5'd3: ALU function used for address and immediate add.
- clk  in  1  system clock; all state changes occur on the rising edge.
- clr  in  1  reset, asynchronous and active-high.
- IR  in  32  instruction register: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15], C IR[18:0].
- Stop  in  1  halt request, sampled at instruction end.
- Run  out  1  high while executing; low in RESET and HALT.
- Illegal  out  1  sticky; set when an undefined opcode is decoded.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout  out  1 each  bus drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin  out  1 each  register load strobes.
- Gra, Grb, Grc  out  1 each  register-field select for Rin/Rout/BAout.
- Read, Write  out  1 each  memory strobes.
- OpCode  out  5  ALU function select.
- State  out  5  current step encoding, debug only.

## Operation
- States: RESET, T0–T7, HALT. Outputs decode combinationally from State and IR[31:27]. Every output is 0 unless listed for the current step.
- Fetch steps:
  - T0: PCout, MARin, Zin, OpCode=INC_CODE.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- R-type (add 3, sub 4, and 5, or 6, shr 7, shl 8):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, OpCode=IR[31:27].
  - T5: Zlowout, Gra, Rin.
- Immediate (addi 12→3, andi 13→5, ori 14→6):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, OpCode=mapped code.
  - T5: Zlowout, Gra, Rin.
- ldi (1): T3 Grb, BAout, Yin; T4 Cout, Zin, ADD_CODE; T5 Zlowout, Gra, Rin.
- ld (0): T3–T4 as ldi; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
- st (2): T3–T4 as ldi; T5 Zlowout, MARin; T6 Gra, Rout, MDRin (Read=0); T7 Write.
- mul (15), div (16): T3 Gra, Rout, Yin; T4 Grb, Rout, Zin, OpCode=IR[31:27]; T5 Zlowout, LOin; T6 Zhighout, HIin.
- mfhi (24): T3 HIout, Gra, Rin.
- mflo (25): T3 LOout, Gra, Rin.
- nop (26): T3, no strobes.
- halt (27): T3, no strobes; next state HALT.
- Any other opcode: T3 sets Illegal; next state HALT.
- Last step of an instruction → T0. If Stop=1 at that edge, the next state is HALT instead of T0.
- HALT is absorbing until clr. It asserts nothing, and Run=0.

## Timing
- clr=1 forces State=RESET immediately, regardless of clk. Effects: all strobes 0, OpCode=0, Run=0, Illegal=0.
- First rising edge with clr=0 moves RESET→T0. Run=1 from T0 onward.
- One step per cycle; no wait states. Memory returns data in the same cycle as Read.
- Instruction latency, counting T0–T2 as 3 fetch cycles:

| Class | Total cycles |
|---|---|
| R-type, immediate, ldi | 6 |
| ld, st | 8 |
| mul, div | 7 |
| mfhi, mflo, nop | 4 |

- IR is stable from the end of T2 until the next T2. Decode in T3+ uses the live IR.
- clr asserted mid-instruction aborts immediately. No partial write completes after the asynchronous edge.
- Stop asserted during non-final steps is ignored. Only its value at a final-step edge counts.

## Test plan
- Reset: assert clr mid-T4 → State=RESET immediately, all outputs 0, Run=0. Release clr → T0 on the next edge with PCout=MARin=Zin=1 and OpCode=12.
- IR=0x28918000 (and r1,r2,r3):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, OpCode=5.
  - T5: Zlowout, Gra, Rin.
  - Then T0. Six cycles total.
- IR=0x6111FFFB (addi, opcode 12):
  - T4: Cout, Zin, OpCode=3, never 12.
  - Following T0: OpCode=12.
- ld (IR=0x00880010) over 8 cycles:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- st: T6 has MDRin=1 with Read=0, and T7 has Write=1.
- mul: T5 LOin, T6 HIin, Zhighout.
- Halt, stop and illegal:
  - IR=0xD8000000 (halt) → HALT after T3, Run=0, held for 10 cycles.
  - Stop=1 at T5 of an add → HALT instead of T0.
  - Opcode 31 → Illegal=1, HALT.
